// File: rtl/yupferris_bitslam.sv
// ---------------------------------------------------------------------------
// yupferris_bitslam
//
// Free-running hex counter and noise source behind an 8-bit pad interface.
// A prescaler divides the pad clock down so a 4-bit digit advances once
// every TICK_CYCLES rising edges. The digit is shown on a 7-segment display,
// and a 16-bit Galois LFSR provides a 1-bit noise stream.
//
// Parameters:
//   TICK_CYCLES  clock edges per digit increment (>= 1)
//   LFSR_SEED    LFSR value loaded on reset (must be nonzero)
//
// Ports:
//   io_in[0]    clk, all state updates on its rising edge
//   io_in[1]    rst, synchronous, active-high
//   io_in[7:2]  not used
//   io_out[6:0] segments, active-high, bit0 = a ... bit6 = g
//   io_out[7]   noise bit (lfsr[0])
// ---------------------------------------------------------------------------
module yupferris_bitslam #(
  parameter int          TICK_CYCLES = 1000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  // A single-cycle tick still needs a 1-bit prescaler so the register and
  // the compare below stay well-formed.
  localparam int            PRE_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

  // Galois feedback taps for a maximal-length 16-bit sequence.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic             clk;
  logic             rst;
  logic [5:0]       unused_pads;

  logic [PRE_W-1:0] prescaler;
  logic [3:0]       digit;
  logic [15:0]      lfsr;
  logic [6:0]       segments;

  assign clk         = io_in[0];
  assign rst         = io_in[1];
  assign unused_pads = io_in[7:2];

  // Prescaler and digit counter. Reset has priority, so a reset landing on
  // the same edge as a prescaler wrap leaves the digit at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      digit     <= 4'd0;
    end else if (prescaler == PRE_LAST) begin
      prescaler <= '0;
      digit     <= digit + 4'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Galois LFSR: shift right and fold the bit shifted out back into the
  // tap positions. A nonzero seed can never reach the all-zero state.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // Hex to 7-segment decode straight from the registered digit, so the
  // display changes on the same edge the digit does. Bit order is gfedcba.
  always_comb begin
    segments = 7'h00;
    case (digit)
      4'h0: segments = 7'h3F;
      4'h1: segments = 7'h06;
      4'h2: segments = 7'h5B;
      4'h3: segments = 7'h4F;
      4'h4: segments = 7'h66;
      4'h5: segments = 7'h6D;
      4'h6: segments = 7'h7D;
      4'h7: segments = 7'h07;
      4'h8: segments = 7'h7F;
      4'h9: segments = 7'h6F;
      4'hA: segments = 7'h77;
      4'hB: segments = 7'h7C;
      4'hC: segments = 7'h39;
      4'hD: segments = 7'h5E;
      4'hE: segments = 7'h79;
      4'hF: segments = 7'h71;
      default: segments = 7'h00;
    endcase
  end

  assign io_out = {lfsr[0], segments};

endmodule

// File: tb/tb_yupferris_bitslam.sv
// ---------------------------------------------------------------------------
// tb_yupferris_bitslam
//
// Drives two copies of yupferris_bitslam (TICK_CYCLES = 4 and 1) from the
// same pad stimulus. A behavioural model counts non-reset edges since the
// last reset and derives the expected digit by division and the expected
// noise bit from the LFSR rule; a compare process checks both copies every
// cycle. Directed steps add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_yupferris_bitslam;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [15:0] LFSR_AFTER [5] = '{
    16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27
  };

  localparam logic [7:0] NOISE_AFTER [5] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] junk = 6'h00;
  logic [7:0] ioIn;
  logic [7:0] ioOut4;
  logic [7:0] ioOut1;

  int          total = 0;
  int          bad = 0;

  // Model state: non-reset edges since last reset, and the LFSR value.
  int          edgeCount = 0;
  logic [15:0] modelLfsr = 16'h0000;
  logic        modelValid = 1'b0;

  assign ioIn = {junk, rst, clk};

  always #5 clk = ~clk;

  yupferris_bitslam #(.TICK_CYCLES(4), .LFSR_SEED(16'hACE1)) dut4 (
    .io_in (ioIn),
    .io_out(ioOut4)
  );

  yupferris_bitslam #(.TICK_CYCLES(1), .LFSR_SEED(16'hACE1)) dut1 (
    .io_in (ioIn),
    .io_out(ioOut1)
  );

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [7:0] expectedOut(input int ticks);
    return {modelLfsr[0], SEG_TABLE[(edgeCount / ticks) % 16]};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] got,
                             input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Drive pad inputs for a number of edges; inputs change 2 time units
  // after each rising edge so they are stable well before the next one.
  task automatic applyStimulus(input logic r, input logic [5:0] j, input int edges);
    for (int i = 0; i < edges; i++) begin
      rst  = r;
      junk = j;
      @(posedge clk);
      #2;
    end
  endtask

  // Model update on every rising edge.
  always @(posedge clk) begin
    if (rst) begin
      edgeCount  <= 0;
      modelLfsr  <= 16'hACE1;
      modelValid <= 1'b1;
    end else if (modelValid) begin
      edgeCount <= edgeCount + 1;
      modelLfsr <= lfsrStep(modelLfsr);
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("dut4_cycle", {8'h00, ioOut4}, {8'h00, expectedOut(4)});
      checkOutput("dut1_cycle", {8'h00, ioOut1}, {8'h00, expectedOut(1)});
    end
  end

  initial begin
    // Reset, then reset again with the unused pads all high.
    applyStimulus(1'b1, 6'h00, 2);
    checkOutput("reset_dut4", {8'h00, ioOut4}, 16'h00BF);
    checkOutput("reset_dut1", {8'h00, ioOut1}, 16'h00BF);
    applyStimulus(1'b1, 6'h3F, 2);
    checkOutput("reset_junk_dut4", {8'h00, ioOut4}, 16'h00BF);
    checkOutput("reset_junk_dut1", {8'h00, ioOut1}, 16'h00BF);

    // First five edges after release: LFSR sequence and early digits.
    for (int e = 1; e <= 5; e++) begin
      applyStimulus(1'b0, 6'($urandom_range(0, 63)), 1);
      checkOutput("lfsr_model", modelLfsr, LFSR_AFTER[e-1]);
      checkOutput("noise_dut4", {15'h0, ioOut4[7]}, {8'h00, NOISE_AFTER[e-1]});
      checkOutput("seg_dut1", {9'h0, ioOut1[6:0]}, {9'h0, SEG_TABLE[e % 16]});
      checkOutput("seg_dut4", {9'h0, ioOut4[6:0]},
                  (e < 4) ? 16'h003F : 16'h0006);
    end
    applyStimulus(1'b0, 6'h15, 3);
    checkOutput("seg_edge8", {9'h0, ioOut4[6:0]}, 16'h005B);
    applyStimulus(1'b0, 6'h2A, 55);
    checkOutput("seg_edge63", {9'h0, ioOut4[6:0]}, 16'h0071);
    applyStimulus(1'b0, 6'h00, 1);
    checkOutput("seg_wrap64", {9'h0, ioOut4[6:0]}, 16'h003F);

    // Reset mid-count.
    applyStimulus(1'b1, 6'h00, 1);
    applyStimulus(1'b0, 6'h00, 10);
    checkOutput("midcount_seg", {9'h0, ioOut4[6:0]}, 16'h005B);
    applyStimulus(1'b1, 6'h00, 1);
    checkOutput("midcount_rst", {8'h00, ioOut4}, 16'h00BF);
    applyStimulus(1'b0, 6'h00, 3);
    checkOutput("rerun_edge3", {9'h0, ioOut4[6:0]}, 16'h003F);
    applyStimulus(1'b0, 6'h00, 1);
    checkOutput("rerun_edge4", {9'h0, ioOut4[6:0]}, 16'h0006);

    // Reset on the very edge that would wrap the prescaler.
    applyStimulus(1'b1, 6'h00, 1);
    applyStimulus(1'b0, 6'h00, 3);
    applyStimulus(1'b1, 6'h00, 1);
    checkOutput("wrap_rst", {8'h00, ioOut4}, 16'h00BF);
    applyStimulus(1'b0, 6'h00, 1);
    checkOutput("wrap_rst_after", {9'h0, ioOut4[6:0]}, 16'h003F);

    // Full LFSR period with the unused pads toggling.
    applyStimulus(1'b1, 6'h00, 1);
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1'b0, 6'(i), 1);
    end
    checkOutput("lfsr_period", modelLfsr, 16'hACE1);
    checkOutput("period_dut1", {8'h00, ioOut1}, 16'h00F1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yupferris_bitslam.md
Name: yupferris_bitslam

Overview:
Small free-running display/noise block packaged behind an 8-bit io_in/io_out pad interface. A prescaled 4-bit hex counter drives a 7-segment hex decoder on io_out[6:0]. A 16-bit Galois LFSR supplies a 1-bit noise stream on io_out[7]. It is a top-level pad-facing design with no handshakes.

Parameters:
TICK_CYCLES, 1000, clock cycles per digit increment; legal range >= 1.
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
io_in  input  8  bit 0 = clk (all state on its rising edge); bit 1 = rst (synchronous, active-high); bits 7:2 ignored.
io_out output 8  bits 6:0 = segments, active-high, bit0=a ... bit6=g; bit 7 = noise bit.

Behaviour:
- Clock and reset:
  - Single clock domain on io_in[0].
  - Reset is sampled only on a rising edge with io_in[1]=1. No asynchronous paths.
- State:
  - prescaler, width ceil(log2(TICK_CYCLES)), minimum 1 bit.
  - digit[3:0].
  - lfsr[15:0].
- Reset values (the edge with rst=1):
  - prescaler=0, digit=0, lfsr=LFSR_SEED.
  - Outputs: io_out[6:0]=7'h3F ("0"), io_out[7]=LFSR_SEED[0] (=1 at default).
- Prescaler, per non-reset edge:
  - If prescaler==TICK_CYCLES-1: prescaler<=0 and digit<=digit+1, mod 16 (F wraps to 0).
  - Else prescaler<=prescaler+1.
  - TICK_CYCLES=1: digit increments every edge.
- Digit timing: the first increment occurs on the TICK_CYCLES-th rising edge after the last reset edge.
- Decoder: combinational from registered digit, so segments change on the same edge as digit. Encodings, gfedcba hex:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- LFSR, per non-reset edge:
  - b = lfsr[0]; lfsr <= (lfsr >> 1) ^ (b ? 16'hB400 : 0).
  - Period is 65535; never reaches 0 from a nonzero seed.
  - io_out[7] = lfsr[0], combinational from the register.
- LFSR sequence from ACE1: E270, 7138, 389C, 1C4E, 0E27, ... io_out[7] = 0,0,0,0,1.
- Reset mid-operation: any edge with rst=1 restores all reset values regardless of prescaler/digit/lfsr state. It overrides a simultaneous wrap/increment. Counting resumes from 0 on the first edge with rst=0.
- io_in[7:2] have no effect on any state or output.
- No X on outputs after the first reset edge.
- Before the first reset, output values are undefined and need not be checked.

Test Plan:
1. Reset check: hold rst=1 for 2 edges -> io_out = 8'hBF (segments 3F, noise 1). Repeat with io_in[7:2]=6'h3F -> identical.
2. TICK_CYCLES=4, release reset:
   - Edges 1-3 -> segments 3F.
   - Edge 4 -> 06.
   - Edge 8 -> 5B.
   - Continue through all 16 digits -> each encoding matches the table.
   - Edge 64 -> wraps to 3F.
3. LFSR sequence, default seed, after reset release -> io_out[7] over edges 1..5 = 0,0,0,0,1. Internal lfsr = E270, 7138, 389C, 1C4E, 0E27.
4. Reset mid-count: TICK_CYCLES=4, run 10 edges (digit=2, segments 5B), assert rst on edge 11 -> segments 3F, io_out[7]=1. After release, next increment at edge 4 of the new run.
5. Simultaneous wrap and reset: TICK_CYCLES=4, assert rst exactly on the 4th edge -> digit stays 0 (3F), no increment.
6. TICK_CYCLES=1 -> segments step 3F, 06, 5B, 4F ... on consecutive edges. 65535-edge run -> lfsr returns to ACE1 and never 0.
